mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001: Parameter LATENCY, default 3, cycles from request capture to mem_resp; legal range 1..15.
REQ-002: Parameter ADDR_WORDS_LOG2, default 8, log2 of storage depth in 16-bit words.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: mem_read  input  1  initiator read request; held until mem_resp.
REQ-006: mem_write  input  1  initiator write request; held until mem_resp.
REQ-007: mem_byte_enable  input  2 (lc3b_mem_wmask)  write byte lanes; bit1 = high byte, bit0 = low byte.
REQ-008: mem_address  input  16 (lc3b_word)  byte address; bit 0 ignored.
REQ-009: mem_wdata  input  16 (lc3b_word)  write data.
REQ-010: mem_resp  output  1  one-cycle completion pulse.
REQ-011: mem_rdata  output  16 (lc3b_word)  read data; valid in the mem_resp cycle of a read.
REQ-012: busy  output  1  high in every state except IDLE.
REQ-013: proto_err  output  1  sticky protocol-violation flag.

Function
REQ-014: FSM states are IDLE, WAIT, RESP, RECOVER.
REQ-015: In IDLE, mem_read or mem_write high at a clock edge captures the address, wdata, byte enables and direction, loads the latency counter with LATENCY-1, and moves to WAIT. If LATENCY=1, the FSM moves directly to RESP.
REQ-016: WAIT decrements the counter each cycle and moves to RESP when the counter reaches 0, so mem_resp is high exactly LATENCY cycles after the capture edge.
REQ-017: RESP drives mem_resp=1 for exactly one cycle and then moves to RECOVER. Reads present storage[captured index] on mem_rdata in that cycle. Writes update storage at the RESP edge.
REQ-018: RECOVER lasts one cycle and ignores all requests; the next state is IDLE. This prevents a request still held high in the cycle after mem_resp from being accepted twice.
REQ-019: Word index is captured_address[ADDR_WORDS_LOG2:1]. Higher address bits are discarded, so addresses wrap modulo the storage depth.
REQ-020: Writes update only the lanes whose enable bit is 1. A write with byte_enable 2'b00 completes with mem_resp but changes no storage.
REQ-021: mem_rdata holds the last read value between responses. It is unchanged by writes and 16'h0000 after reset.
REQ-022: Capture uses values sampled at the capture edge. Changes to address, data or enables during WAIT have no effect.
REQ-023: mem_read and mem_write both high at capture: the request is serviced as a write and proto_err is set.
REQ-024: A request dropped before mem_resp (both mem_read and mem_write low in WAIT) sets proto_err. The transaction still completes and pulses mem_resp.
REQ-025: proto_err stays set until reset.

Reset
REQ-026: Asserting rst_n low forces IDLE, mem_resp=0, mem_rdata=16'h0000, busy=0, proto_err=0 and counter=0 immediately, without waiting for a clock edge.
REQ-027: Reset in the middle of a transaction aborts it. No mem_resp is issued and a pending write does not modify storage.
REQ-028: Storage contents are not reset.
REQ-029: After rst_n is deasserted, the first edge with a request high captures that request.

Structure
REQ-030: The state enum lc3b_memresp_state belongs in the shared lc3b_types package. lc3b_word and lc3b_mem_wmask are reused from that package.
REQ-031: Storage is a sub-module mem_array: 2^ADDR_WORDS_LOG2 x 16 bits, synchronous byte-lane write, combinational read. The FSM and counter live in mem_responder.

Verification
REQ-032: Scenario 1 (write then read). Write 0x1234 to address 0x0040, enables 2'b11, then read 0x0040. Required: mem_resp exactly 3 cycles after each capture; read mem_rdata=0x1234.
REQ-033: Scenario 2 (byte write). Preload 0xAAAA at 0x0010, write 0x55CC with enables 2'b01, then read 0x0010. Required: mem_rdata=0xAACC.
REQ-034: Scenario 3 (held request). Hold mem_read high for 2 cycles after mem_resp. Required: exactly one mem_resp pulse; next capture no earlier than 2 cycles after the pulse.
REQ-035: Scenario 4 (protocol errors). Assert mem_read and mem_write together with wdata 0xBEEF. Required: treated as write, proto_err=1 and sticky; a later read of that address returns 0xBEEF.
REQ-036: Scenario 5 (reset mid-write). Drop rst_n in WAIT of a write of 0xFFFF to a location holding 0x0001. Required: no mem_resp; all outputs at reset values immediately; a later read returns 0x0001.
REQ-037: Scenario 6 (address wrap and minimum latency). With ADDR_WORDS_LOG2=8 and LATENCY=1, write 0x7777 to 0x0202 and read 0x0002. Required: mem_rdata=0x7777; mem_resp 1 cycle after capture.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: bus word, write byte mask and the memory-responder FSM states.
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESP    = 2'd2,
        RECOVER = 2'd3
    } lc3b_memresp_state;
endpackage

// File: rtl/mem_responder_if.sv
// Initiator <-> responder memory handshake bus.
interface mem_responder_if;
    import lc3b_types::*;

    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    logic          mem_resp;
    lc3b_word      mem_rdata;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/mem_array.sv
// Word storage built from two independent byte lanes: synchronous lane write, combinational read.
module mem_array
    import lc3b_types::*;
#(
    parameter int ADDR_WORDS_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  lc3b_mem_wmask              be_i,
    input  logic [ADDR_WORDS_LOG2-1:0] idx_i,
    input  lc3b_word                   wdata_i,
    output lc3b_word                   rdata_o
);
    localparam int DEPTH = 1 << ADDR_WORDS_LOG2;

    for (genvar b = 0; b < 2; b++) begin : g_lane
        // No reset: contents survive rst_n.
        logic [7:0] lane_q [DEPTH];

        always_ff @(posedge clk) begin
            if (we_i && be_i[b]) lane_q[idx_i] <= wdata_i[b*8 +: 8];
        end

        assign rdata_o[b*8 +: 8] = lane_q[idx_i];
    end
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: captures one request, answers LATENCY cycles later,
// then spends one RECOVER cycle so a request still held after mem_resp is not re-accepted.
module mem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY         = 3,  // 1..15
    parameter int ADDR_WORDS_LOG2 = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus,
    output logic            busy,
    output logic            proto_err
);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    lc3b_memresp_state          state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [ADDR_WORDS_LOG2-1:0] idx_q, idx_d;
    lc3b_word                   wdata_q, wdata_d;
    lc3b_word                   rdata_q, rdata_d;
    lc3b_mem_wmask              be_q, be_d;
    logic                       wr_q, wr_d;
    logic                       perr_q, perr_d;

    logic     req;
    logic     arr_we;
    lc3b_word arr_rdata;

    assign req = bus.mem_read | bus.mem_write;

    // Address bit 0 and bits above the storage depth are intentionally discarded.
    if (ADDR_WORDS_LOG2 < 15) begin : g_unused_hi
        logic unused_addr;
        assign unused_addr = ^{bus.mem_address[15:ADDR_WORDS_LOG2+1], bus.mem_address[0]};
    end else begin : g_unused_lo
        logic unused_addr;
        assign unused_addr = bus.mem_address[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        perr_d  = perr_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = bus.mem_address[ADDR_WORDS_LOG2:1];
                    wdata_d = bus.mem_wdata;
                    be_d    = bus.mem_byte_enable;
                    wr_d    = bus.mem_write;  // read+write together is serviced as a write
                    cnt_d   = CNT_LOAD;
                    if (bus.mem_read && bus.mem_write) perr_d = 1'b1;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!req) perr_d = 1'b1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (!wr_q) rdata_d = arr_rdata;
                state_d = RECOVER;
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = rdata_q;
        arr_we        = 1'b0;
        busy          = (state_q != IDLE);
        proto_err     = perr_q;
        if (state_q == RESP) begin
            bus.mem_resp = 1'b1;
            arr_we       = wr_q;
            if (!wr_q) bus.mem_rdata = arr_rdata;
        end
    end

    mem_array #(
        .ADDR_WORDS_LOG2(ADDR_WORDS_LOG2)
    ) u_mem_array (
        .clk     (clk),
        .we_i    (arr_we),
        .be_i    (be_q),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=3 instance for the main scenarios and a
// LATENCY=1 instance for the wrap / minimum-latency case.
module tb_mem_responder;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if bus3();
    mem_responder_if bus1();
    logic busy3, perr3, busy1, perr1;

    mem_responder #(.LATENCY(3), .ADDR_WORDS_LOG2(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .busy(busy3), .proto_err(perr3)
    );
    mem_responder #(.LATENCY(1), .ADDR_WORDS_LOG2(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1), .proto_err(perr1)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr, input lc3b_mem_wmask be,
                         input lc3b_word a, input lc3b_word d);
        if (sel) begin
            bus1.mem_read = rd; bus1.mem_write = wr; bus1.mem_byte_enable = be;
            bus1.mem_address = a; bus1.mem_wdata = d;
        end else begin
            bus3.mem_read = rd; bus3.mem_write = wr; bus3.mem_byte_enable = be;
            bus3.mem_address = a; bus3.mem_wdata = d;
        end
    endtask

    function automatic logic resp(input bit sel);
        return sel ? bus1.mem_resp : bus3.mem_resp;
    endfunction

    function automatic lc3b_word rdat(input bit sel);
        return sel ? bus1.mem_rdata : bus3.mem_rdata;
    endfunction

    // One full transaction; lat = negedges after the capture edge until mem_resp (0 = none).
    // corrupt scrambles address/data/enables right after capture.
    task automatic txn(input bit sel, input logic rd, input logic wr, input lc3b_mem_wmask be,
                       input lc3b_word a, input lc3b_word d, input bit corrupt,
                       output int lat, output lc3b_word rd_o);
        @(negedge clk);
        drive(sel, rd, wr, be, a, d);
        @(posedge clk);
        lat  = 0;
        rd_o = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (corrupt && i == 1) drive(sel, rd, wr, ~be, ~a, ~d);
            if (resp(sel)) begin
                lat  = i;
                rd_o = rdat(sel);
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int       lat, pulses, first;
        lc3b_word rd;

        drive(0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        chk("rst resp",  32'(bus3.mem_resp), 32'd0);
        chk("rst rdata", 32'(bus3.mem_rdata), 32'h0000);
        chk("rst busy",  32'(busy3), 32'd0);
        chk("rst perr",  32'(perr3), 32'd0);
        rst_n = 1'b1;

        // Scenario 1: write then read
        txn(0, 1'b0, 1'b1, 2'b11, 16'h0040, 16'h1234, 1'b0, lat, rd);
        chk("s1 wr lat", 32'(lat), 32'd3);
        txn(0, 1'b1, 1'b0, 2'b11, 16'h0040, 16'h0000, 1'b0, lat, rd);
        chk("s1 rd lat", 32'(lat), 32'd3);
        chk("s1 rdata",  32'(rd), 32'h1234);

        // Scenario 2: byte-lane write, rdata held across writes, empty-mask write
        txn(0, 1'b0, 1'b1, 2'b11, 16'h0010, 16'hAAAA, 1'b0, lat, rd);
        txn(0, 1'b0, 1'b1, 2'b01, 16'h0010, 16'h55CC, 1'b0, lat, rd);
        chk("s2 rdata hold", 32'(bus3.mem_rdata), 32'h1234);
        txn(0, 1'b0, 1'b1, 2'b00, 16'h0010, 16'h0000, 1'b0, lat, rd);
        chk("s2 be00 lat", 32'(lat), 32'd3);
        txn(0, 1'b1, 1'b0, 2'b11, 16'h0010, 16'h0000, 1'b0, lat, rd);
        chk("s2 rdata", 32'(rd), 32'hAACC);

        // Inputs changing during WAIT are ignored
        txn(0, 1'b0, 1'b1, 2'b11, 16'h0030, 16'h5A5A, 1'b1, lat, rd);
        txn(0, 1'b1, 1'b0, 2'b11, 16'h0030, 16'h0000, 1'b0, lat, rd);
        chk("capture rdata", 32'(rd), 32'h5A5A);

        // Scenario 3: read held two cycles past mem_resp
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'b11, 16'h0030, 16'h0000);
        @(posedge clk);
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus3.mem_resp) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (i == 4) chk("s3 busy recover", 32'(busy3), 32'd1);
            if (i == 5) begin
                chk("s3 busy idle", 32'(busy3), 32'd0);
                drive(0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
            end
        end
        chk("s3 pulses", 32'(pulses), 32'd1);
        chk("s3 first",  32'(first), 32'd3);
        txn(0, 1'b1, 1'b0, 2'b11, 16'h0030, 16'h0000, 1'b0, lat, rd);
        chk("s3 next lat", 32'(lat), 32'd3);

        // Scenario 4: read+write together
        txn(0, 1'b1, 1'b1, 2'b11, 16'h0080, 16'hBEEF, 1'b0, lat, rd);
        chk("s4 lat",  32'(lat), 32'd3);
        chk("s4 perr", 32'(perr3), 32'd1);
        txn(0, 1'b1, 1'b0, 2'b11, 16'h0080, 16'h0000, 1'b0, lat, rd);
        chk("s4 rdata",  32'(rd), 32'hBEEF);
        chk("s4 sticky", 32'(perr3), 32'd1);

        // Scenario 5: reset during WAIT of a write
        txn(0, 1'b0, 1'b1, 2'b11, 16'h0020, 16'h0001, 1'b0, lat, rd);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 2'b11, 16'h0020, 16'hFFFF);
        @(posedge clk);
        @(negedge clk);
        chk("s5 busy pre", 32'(busy3), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("s5 resp",  32'(bus3.mem_resp), 32'd0);
        chk("s5 rdata", 32'(bus3.mem_rdata), 32'h0000);
        chk("s5 busy",  32'(busy3), 32'd0);
        chk("s5 perr",  32'(perr3), 32'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus3.mem_resp) pulses++;
        end
        chk("s5 no resp", 32'(pulses), 32'd0);
        drive(0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(0, 1'b1, 1'b0, 2'b11, 16'h0020, 16'h0000, 1'b0, lat, rd);
        chk("s5 lat",   32'(lat), 32'd3);
        chk("s5 rdata", 32'(rd), 32'h0001);

        // Request dropped during WAIT still completes but flags an error
        chk("drop perr pre", 32'(perr3), 32'd0);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'b11, 16'h0020, 16'h0000);
        @(posedge clk);
        first = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) drive(0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
            if (bus3.mem_resp && first == 0) first = i;
        end
        chk("drop resp",  32'(first), 32'd3);
        chk("drop perr",  32'(perr3), 32'd1);
        chk("drop rdata", 32'(bus3.mem_rdata), 32'h0001);

        // Scenario 6: address wrap at LATENCY=1
        txn(1, 1'b0, 1'b1, 2'b11, 16'h0202, 16'h7777, 1'b0, lat, rd);
        chk("s6 wr lat", 32'(lat), 32'd1);
        txn(1, 1'b1, 1'b0, 2'b11, 16'h0002, 16'h0000, 1'b0, lat, rd);
        chk("s6 rd lat", 32'(lat), 32'd1);
        chk("s6 rdata",  32'(rd), 32'h7777);
        chk("s6 perr",   32'(perr1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
